// File: rtl/tt_fpga_top.sv
// Tiny Tapeout scan-chain demonstrator top: TCK generator, TCK-paced 8N1 receiver,
// address/data tap access with serial readback on TDO.
module tt_fpga_top #(
    parameter int CLK_DIV  = 12,
    parameter int NUM_TAPS = 4
) (
    input  logic       CLK,
    input  logic       TRST,
    input  logic       MODE,
    input  logic       RX,
    input  logic       TMS,
    input  logic [7:0] I_DATA,
    output logic [7:0] O_DATA,
    output logic       TCK,
    output logic       TDI,
    output logic       TDO,
    output logic       RTCK,
    output logic       TX,
    output logic [4:0] LED
);

    localparam int HALF   = CLK_DIV / 2;
    localparam int CW     = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int AW     = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int RO_TAP = NUM_TAPS - 1;

    localparam logic [7:0] ADDR_NONE = 8'hFF;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DATA    = 2'd1;
    localparam logic [1:0] S_STOP    = 2'd2;

    logic [CW-1:0] r_div_cnt;
    logic          r_tck, r_rtck, r_tx;
    logic          r_rx_meta, r_rx_sync;
    logic [1:0]    r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_byte_valid, r_byte_tms;
    logic [7:0]    r_addr;
    logic          r_tdo, r_tdi;
    logic [7:0]    r_tdo_sr;
    logic [7:0]    r_tap [NUM_TAPS];

    logic          w_half_end, w_rise_tick, w_sel, w_sel_ro, w_start;
    logic [AW-1:0] w_idx;
    logic [7:0]    w_tap_src;

    assign w_half_end  = (r_div_cnt == CW'(HALF - 1));
    assign w_rise_tick = w_half_end & ~r_tck;
    assign w_sel       = (r_addr < 8'(NUM_TAPS));
    assign w_sel_ro    = (r_addr == 8'(RO_TAP));
    assign w_idx       = r_addr[AW-1:0];
    assign w_start     = w_rise_tick && (r_state == S_IDLE) && !r_rx_sync;
    // The read-only tap captures I_DATA on this very tick, so serialize the fresh value.
    assign w_tap_src   = w_sel_ro ? I_DATA : r_tap[w_idx];

    always_ff @(posedge CLK or negedge TRST) begin
        if (!TRST) begin
            r_div_cnt <= '0;
            r_tck     <= 1'b0;
            r_rtck    <= 1'b0;
            r_tx      <= 1'b1;
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_div_cnt <= w_half_end ? '0 : r_div_cnt + 1'b1;
            if (w_half_end) r_tck <= ~r_tck;
            r_rtck    <= r_tck;
            r_tx      <= RX;
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge CLK or negedge TRST) begin
        if (!TRST) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_byte_tms   <= 1'b0;
            r_addr       <= ADDR_NONE;
            r_tdo        <= 1'b1;
            r_tdo_sr     <= 8'hFF;
            r_tdi        <= 1'b1;
        end else begin
            r_byte_valid <= 1'b0;
            if (r_byte_valid && !r_byte_tms)
                r_addr <= (r_shift < 8'(NUM_TAPS)) ? r_shift : ADDR_NONE;
            if (w_rise_tick) begin
                r_tdi <= r_rx_sync;
                case (r_state)
                    S_IDLE: begin
                        if (!r_rx_sync) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                            r_tdo     <= w_sel ? w_tap_src[0] : 1'b1;
                            r_tdo_sr  <= w_sel ? {1'b1, w_tap_src[7:1]} : 8'hFF;
                        end
                    end
                    S_DATA: begin
                        // Ones fill behind the readback so TDO returns high after bit 7.
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_tdo     <= r_tdo_sr[0];
                        r_tdo_sr  <= {1'b1, r_tdo_sr[7:1]};
                        if (r_bit_cnt == 3'd7) r_state <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (r_rx_sync) begin
                            r_byte_valid <= 1'b1;
                            r_byte_tms   <= TMS;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge TRST) begin
        if (!TRST) begin
            for (int i = 0; i < NUM_TAPS; i++) r_tap[i] <= '0;
        end else begin
            if (w_start && w_sel_ro) r_tap[RO_TAP] <= I_DATA;
            if (r_byte_valid && r_byte_tms && MODE && w_sel && !w_sel_ro)
                r_tap[w_idx] <= r_shift;
        end
    end

    assign TCK    = r_tck;
    assign RTCK   = r_rtck;
    assign TX     = r_tx;
    assign TDI    = r_tdi;
    assign TDO    = r_tdo;
    assign O_DATA = MODE ? r_tap[2] : I_DATA;
    assign LED    = r_tap[1][4:0];

endmodule

// File: tb/tb_tt_fpga_top.sv
// Directed bench for tt_fpga_top: frame table with expected O_DATA/LED/TDO readback,
// plus reset, TCK timing and mid-frame reset sequences.
module tb_tt_fpga_top;

    logic       CLK, TRST, MODE, RX, TMS;
    logic [7:0] I_DATA, O_DATA;
    logic       TCK, TDI, TDO, RTCK, TX;
    logic [4:0] LED;

    int tests  = 0;
    int errors = 0;

    tt_fpga_top #(.CLK_DIV(12), .NUM_TAPS(4)) dut (
        .CLK(CLK), .TRST(TRST), .MODE(MODE), .RX(RX), .TMS(TMS), .I_DATA(I_DATA),
        .O_DATA(O_DATA), .TCK(TCK), .TDI(TDI), .TDO(TDO), .RTCK(RTCK), .TX(TX), .LED(LED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] data;
        logic       tms;
        logic       mode;
        logic       stop;
        logic [7:0] idata;
        logic [7:0] exp_o;
        logic [4:0] exp_led;
        logic [7:0] exp_tdo;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Returns at the first CLK negedge where TCK is seen at lvl after being elsewhere.
    task automatic wait_tck(input logic lvl, output int n);
        logic prev;
        prev = TCK;
        n = 0;
        while (n < 64) begin
            @(negedge CLK);
            n++;
            if (prev !== lvl && TCK === lvl) return;
            prev = TCK;
        end
        chk("tck_edge_timeout", 32'(n), 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic tms, input logic stop,
                              output logic [7:0] tdo_bits);
        int n;
        TMS = tms;
        wait_tck(1'b0, n);
        RX = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_tck(1'b0, n);
            tdo_bits[i] = TDO;
            RX = d[i];
        end
        wait_tck(1'b0, n);
        RX = stop;
        wait_tck(1'b0, n);
        RX = 1'b1;
    endtask

    initial begin
        int n;
        logic [7:0] tdo_bits;

        //          data   tms  mode stop idata  exp_o  led    tdo
        vecs[0]  = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 5'h00, 8'hFF};
        vecs[1]  = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 5'h00, 8'hFF};
        vecs[2]  = '{8'h02, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 5'h00, 8'h00};
        vecs[3]  = '{8'h7F, 1'b1, 1'b1, 1'b1, 8'h00, 8'h7F, 5'h00, 8'h00};
        vecs[4]  = '{8'h08, 1'b1, 1'b1, 1'b1, 8'h00, 8'h08, 5'h00, 8'h7F};
        vecs[5]  = '{8'h5A, 1'b0, 1'b1, 1'b1, 8'h00, 8'h08, 5'h00, 8'h08};
        vecs[6]  = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'h00, 8'h08, 5'h00, 8'hFF};
        vecs[7]  = '{8'h01, 1'b0, 1'b1, 1'b1, 8'h00, 8'h08, 5'h00, 8'hFF};
        vecs[8]  = '{8'h1F, 1'b1, 1'b1, 1'b1, 8'h00, 8'h08, 5'h1F, 8'h00};
        vecs[9]  = '{8'h03, 1'b0, 1'b1, 1'b1, 8'h00, 8'h08, 5'h1F, 8'h1F};
        vecs[10] = '{8'h55, 1'b1, 1'b1, 1'b1, 8'h3C, 8'h08, 5'h1F, 8'h3C};
        vecs[11] = '{8'h02, 1'b0, 1'b1, 1'b1, 8'h3C, 8'h08, 5'h1F, 8'h3C};
        vecs[12] = '{8'h99, 1'b1, 1'b0, 1'b1, 8'hC3, 8'hC3, 5'h1F, 8'h08};
        vecs[13] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'hC3, 8'h08, 5'h1F, 8'h08};
        vecs[14] = '{8'hAB, 1'b1, 1'b1, 1'b0, 8'hC3, 8'h08, 5'h1F, 8'h00};
        vecs[15] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'hC3, 8'h08, 5'h1F, 8'h00};

        TRST = 1'b0; MODE = 1'b1; RX = 1'b1; TMS = 1'b0; I_DATA = 8'h00;
        #23;
        chk("rst_tck",  32'(TCK),    32'd0);
        chk("rst_rtck", 32'(RTCK),   32'd0);
        chk("rst_tdi",  32'(TDI),    32'd1);
        chk("rst_tdo",  32'(TDO),    32'd1);
        chk("rst_tx",   32'(TX),     32'd1);
        chk("rst_led",  32'(LED),    32'd0);
        chk("rst_odata",32'(O_DATA), 32'd0);
        @(negedge CLK);
        TRST = 1'b1;

        wait_tck(1'b1, n);
        wait_tck(1'b1, n);
        chk("tck_period", 32'(n), 32'd12);
        chk("rtck_lag_lo", 32'(RTCK), 32'd0);
        @(negedge CLK);
        chk("rtck_lag_hi", 32'(RTCK), 32'd1);
        wait_tck(1'b0, n);
        chk("tck_high_time", 32'(n), 32'd5);
        chk("rtck_fall_lag", 32'(RTCK), 32'd1);

        for (int i = 0; i < 16; i++) begin
            MODE   = vecs[i].mode;
            I_DATA = vecs[i].idata;
            send_frame(vecs[i].data, vecs[i].tms, vecs[i].stop, tdo_bits);
            chk($sformatf("vec%0d_tdo", i),   32'(tdo_bits), 32'(vecs[i].exp_tdo));
            chk($sformatf("vec%0d_odata", i), 32'(O_DATA),   32'(vecs[i].exp_o));
            chk($sformatf("vec%0d_led", i),   32'(LED),      32'(vecs[i].exp_led));
            chk($sformatf("vec%0d_tdo_idle", i), 32'(TDO),   32'd1);
        end

        // Mid-frame reset: start a data frame, check TX loopback, then pull TRST.
        MODE = 1'b1;
        TMS  = 1'b1;
        wait_tck(1'b0, n);
        RX = 1'b0;
        wait_tck(1'b0, n);
        RX = 1'b0;
        @(negedge CLK);
        chk("tx_loopback", 32'(TX), 32'd0);
        wait_tck(1'b1, n);
        @(negedge CLK);
        chk("tdi_sample", 32'(TDI), 32'd0);
        wait_tck(1'b0, n);
        RX = 1'b1;
        @(negedge CLK);
        TRST = 1'b0;
        #1;
        chk("mid_rst_odata", 32'(O_DATA), 32'd0);
        chk("mid_rst_led",   32'(LED),    32'd0);
        chk("mid_rst_tdo",   32'(TDO),    32'd1);
        chk("mid_rst_tck",   32'(TCK),    32'd0);
        @(negedge CLK);
        TRST = 1'b1;

        send_frame(8'h02, 1'b0, 1'b1, tdo_bits);
        chk("post_rst_tdo_none", 32'(tdo_bits), 32'hFF);
        send_frame(8'h44, 1'b1, 1'b1, tdo_bits);
        chk("post_rst_tdo_tap2", 32'(tdo_bits), 32'h00);
        chk("post_rst_odata",    32'(O_DATA),   32'h44);
        chk("post_rst_led",      32'(LED),      32'h00);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
